pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch sequencer owning the PC; resolves jumps, conditional
// jumps, load-use stalls and HALT, and feeds decode either the fetched word or a NOP bubble.
module pc_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int BR_LAT   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [23:0]     imem_data,
    input  logic [3:0]      flags,
    output logic [PC_W-1:0] imem_addr,
    output logic [23:0]     ins_out,
    output logic            ins_valid,
    output logic            halted,
    output logic            br_taken
);
    localparam int CW = $clog2(BR_LAT + 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, BR_WAIT = 2'd2, HALTED = 2'd3;

    logic [1:0]      r_state, w_state;
    logic [PC_W-1:0] r_pc, w_pc, r_tgt, w_tgt;
    logic            r_squash, w_squash;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [1:0]      r_sel, w_sel;
    logic [23:0]     r_ins, w_ins;
    logic            r_valid, w_valid, r_br, w_br;
    logic [4:0]      w_op;
    logic [PC_W-1:0] w_inc;

    assign w_op  = imem_data[23:19];
    assign w_inc = r_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_pc     <= PC_W'(RESET_PC);
            r_squash <= 1'b0;
            r_cnt    <= '0;
            r_tgt    <= '0;
            r_sel    <= '0;
            r_ins    <= '0;
            r_valid  <= 1'b0;
            r_br     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_squash <= w_squash;
            r_cnt    <= w_cnt;
            r_tgt    <= w_tgt;
            r_sel    <= w_sel;
            r_ins    <= w_ins;
            r_valid  <= w_valid;
            r_br     <= w_br;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_squash = r_squash;
        w_cnt    = r_cnt;
        w_tgt    = r_tgt;
        w_sel    = r_sel;
        w_ins    = '0;
        w_valid  = 1'b0;
        w_br     = 1'b0;
        case (r_state)
            IDLE, HALTED: if (start) begin
                w_state  = RUN;
                w_pc     = w_inc;
                w_squash = 1'b0;
            end
            RUN: if (r_squash) begin
                w_pc     = w_inc;
                w_squash = 1'b0;
            end else if (w_op == 5'b11000) begin
                w_pc     = imem_data[8:1];
                w_squash = 1'b1;
            end else if (w_op[4:2] == 3'b111) begin
                w_tgt   = imem_data[8:1];
                w_sel   = imem_data[20:19];
                w_cnt   = CW'(BR_LAT);
                w_state = BR_WAIT;
            end else if (w_op == 5'b11001) begin
                w_state = HALTED;
            end else begin
                // LD holds the PC so the word after it is fetched again, costing one bubble
                w_ins    = imem_data;
                w_valid  = 1'b1;
                w_pc     = (w_op == 5'b10100) ? r_pc : w_inc;
                w_squash = (w_op == 5'b10100);
            end
            default: begin
                w_cnt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_pc     = flags[r_sel] ? r_tgt : r_pc;
                    w_br     = flags[r_sel];
                    w_squash = 1'b1;
                    w_state  = RUN;
                end
            end
        endcase
    end

    always_comb begin
        imem_addr = r_pc;
        ins_out   = r_ins;
        ins_valid = r_valid;
        br_taken  = r_br;
        halted    = (r_state == IDLE) || (r_state == HALTED);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed cycle-by-cycle check of pc_sequencer against a hand-traced program.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] imem_data = '0;
    logic [3:0]  flags = '0;
    logic [7:0]  imem_addr;
    logic [23:0] ins_out;
    logic        ins_valid, halted, br_taken;
    logic [23:0] mem [0:255];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_step = 0;

    pc_sequencer #(.PC_W(8), .RESET_PC(0), .BR_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .imem_data(imem_data), .flags(flags),
        .imem_addr(imem_addr), .ins_out(ins_out), .ins_valid(ins_valid),
        .halted(halted), .br_taken(br_taken)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", tag, n_step, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] e_pc, input logic [23:0] e_ins, input logic e_v,
                        input logic e_br, input logic e_h);
        @(posedge clk);
        #1;
        n_step++;
        chk("imem_addr", 24'(imem_addr), 24'(e_pc));
        chk("ins_out", ins_out, e_ins);
        chk("ins_valid", 24'(ins_valid), 24'(e_v));
        chk("br_taken", 24'(br_taken), 24'(e_br));
        chk("halted", 24'(halted), 24'(e_h));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {16'h0100, 8'(i)};
        mem[8'h00] = 24'h100001; mem[8'h01] = 24'h180002;
        mem[8'h02] = 24'h100003; mem[8'h03] = 24'h180004;
        mem[8'h05] = 24'hC00040; mem[8'h21] = 24'hC00010;
        mem[8'h08] = 24'hA00123; mem[8'h0C] = 24'hC80000;
        mem[8'h0E] = 24'hC00020; mem[8'h10] = 24'hF00080;
        mem[8'h41] = 24'hC00020; mem[8'h12] = 24'hC001FC;

        @(posedge clk);
        step(8'h00, 24'h0, 0, 0, 1);
        reset = 1'b1;
        step(8'h00, 24'h0, 0, 0, 1);
        start = 1'b1;
        step(8'h01, 24'h0, 0, 0, 0);
        start = 1'b0;
        step(8'h02, 24'h100001, 1, 0, 0);
        step(8'h03, 24'h180002, 1, 0, 0);
        step(8'h04, 24'h100003, 1, 0, 0);
        step(8'h05, 24'h180004, 1, 0, 0);
        step(8'h06, 24'h010004, 1, 0, 0);
        step(8'h20, 24'h0, 0, 0, 0);
        step(8'h21, 24'h0, 0, 0, 0);
        step(8'h22, 24'h010020, 1, 0, 0);
        step(8'h08, 24'h0, 0, 0, 0);
        step(8'h09, 24'h0, 0, 0, 0);
        step(8'h09, 24'hA00123, 1, 0, 0);
        step(8'h0A, 24'h0, 0, 0, 0);
        step(8'h0B, 24'h010009, 1, 0, 0);
        start = 1'b1;
        step(8'h0C, 24'h01000A, 1, 0, 0);
        start = 1'b0;
        step(8'h0D, 24'h01000B, 1, 0, 0);
        step(8'h0D, 24'h0, 0, 0, 1);
        step(8'h0D, 24'h0, 0, 0, 1);
        start = 1'b1;
        step(8'h0E, 24'h0, 0, 0, 0);
        start = 1'b0;
        step(8'h0F, 24'h01000D, 1, 0, 0);
        flags = 4'b0100;
        step(8'h10, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h40, 24'h0, 0, 1, 0);
        step(8'h41, 24'h0, 0, 0, 0);
        step(8'h42, 24'h010040, 1, 0, 0);
        flags = 4'b1011;
        step(8'h10, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h11, 24'h0, 0, 0, 0);
        step(8'h12, 24'h0, 0, 0, 0);
        step(8'h13, 24'h010011, 1, 0, 0);
        step(8'hFE, 24'h0, 0, 0, 0);
        step(8'hFF, 24'h0, 0, 0, 0);
        step(8'h00, 24'h0100FE, 1, 0, 0);
        step(8'h01, 24'h0100FF, 1, 0, 0);
        step(8'h02, 24'h100001, 1, 0, 0);

        reset = 1'b0;
        step(8'h00, 24'h0, 0, 0, 1);
        reset = 1'b1;
        mem[8'h00] = 24'hF00080;
        flags = 4'b0100;
        start = 1'b1;
        step(8'h01, 24'h0, 0, 0, 0);
        start = 1'b0;
        step(8'h01, 24'h0, 0, 0, 0);
        reset = 1'b0;
        step(8'h00, 24'h0, 0, 0, 1);
        reset = 1'b1;
        step(8'h00, 24'h0, 0, 0, 1);
        step(8'h00, 24'h0, 0, 0, 1);
        step(8'h00, 24'h0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
